// File: rtl/vec_pkg.sv
// ----------------------------------------------------------------------------
// vec_pkg
// Shared definitions for the scalar-to-vector issue path.
//   OPCODE_VEC / OPCODE_VLOAD / OPCODE_VSTORE : major opcodes of vector ops
//   FUNCT3_CFG                                : funct3 marking vset{i}vl{i}
//   vec_entry_t                               : 96-bit queue entry
//                                               {instr, rs2, rs1}, MSB first
//   helper functions for classifying/decoding the head entry
// ----------------------------------------------------------------------------
package vec_pkg;

    localparam logic [6:0] OPCODE_VEC    = 7'b1010111;
    localparam logic [6:0] OPCODE_VLOAD  = 7'b0000111;
    localparam logic [6:0] OPCODE_VSTORE = 7'b0100111;
    localparam logic [2:0] FUNCT3_CFG    = 3'b111;

    // instr[31:30] selecting vsetvl (vtype taken from rs2)
    localparam logic [1:0] CFG_FMT_VSETVL = 2'b10;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs2;
        logic [31:0] rs1;
    } vec_entry_t;

    // True for vsetvl / vsetvli / vsetivli.
    function automatic logic is_cfg_op(input logic [6:0] opcode,
                                       input logic [2:0] funct3);
        return (opcode == OPCODE_VEC) && (funct3 == FUNCT3_CFG);
    endfunction

    // SEW field of a config op: vsetvl takes it from rs2[5:3], the immediate
    // forms from instr[25:23]. Reserved codes pass through untouched.
    function automatic logic [2:0] cfg_sew(input logic [1:0] fmt,
                                           input logic [2:0] imm_sew,
                                           input logic [2:0] rs2_sew);
        return (fmt == CFG_FMT_VSETVL) ? rs2_sew : imm_sew;
    endfunction

    // True for vector loads/stores (for downstream decode use).
    function automatic logic is_vec_mem_op(input logic [6:0] opcode);
        return (opcode == OPCODE_VLOAD) || (opcode == OPCODE_VSTORE);
    endfunction

endpackage

// File: rtl/vec_issue_queue.sv
// ----------------------------------------------------------------------------
// vec_issue_queue
// In-order FIFO between the scalar core and the vector decoder. Each entry
// packs the instruction word with its scalar rs2/rs1 operands. Config ops
// (vset*) are absorbed at the head: they update sew_temp and are popped
// without ever being presented to the decoder.
//
// Ports
//   clk               clock, all state on rising edge
//   rst               synchronous active-low reset
//   issue_valid       scalar core offers an entry
//   issue_instr       instruction word
//   issue_rs1         scalar rs1 value
//   issue_rs2         scalar rs2 value
//   issue_ready       queue accepts an entry this cycle
//   flush             discard all queued entries
//   instruction_in    head entry {instr, rs2, rs1}, zero when not valid
//   valid_instruction head entry valid for decoder
//   ready_vector      decoder consumes head this cycle
//   sew_temp          current SEW encoding
//   pending_count     occupied entries
// ----------------------------------------------------------------------------
module vec_issue_queue
    import vec_pkg::*;
#(
    parameter int unsigned INSTRUCTION_BITS  = 32,
    parameter int unsigned SCALAR_DATA_WIDTH = 32,
    parameter int unsigned DATA_FROM_SCALAR  = 96,
    parameter int unsigned DEPTH             = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [INSTRUCTION_BITS-1:0]   issue_instr,
    input  logic [SCALAR_DATA_WIDTH-1:0]  issue_rs1,
    input  logic [SCALAR_DATA_WIDTH-1:0]  issue_rs2,
    output logic                          issue_ready,
    input  logic                          flush,
    output logic [DATA_FROM_SCALAR-1:0]   instruction_in,
    output logic                          valid_instruction,
    input  logic                          ready_vector,
    output logic [2:0]                    sew_temp,
    output logic [$clog2(DEPTH+1)-1:0]    pending_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    // Storage is intentionally not reset; pointers/count define validity.
    logic [DATA_FROM_SCALAR-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       sew_q, sew_d;

    vec_entry_t push_entry;
    vec_entry_t head_entry;
    logic       not_empty;
    logic       head_cfg;
    logic       push;
    logic       pop;

    // ------------------------------------------------------------------
    // Head decode
    // ------------------------------------------------------------------
    always_comb begin
        push_entry.instr = issue_instr;
        push_entry.rs2   = issue_rs2;
        push_entry.rs1   = issue_rs1;
    end

    assign head_entry = mem_q[head_q];
    assign not_empty  = (count_q != '0);
    assign head_cfg   = not_empty &&
                        is_cfg_op(head_entry.instr[6:0], head_entry.instr[14:12]);

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // Depends only on registered count plus rst/flush, never on the
    // same-cycle pop, so a full queue reopens one cycle after draining.
    assign issue_ready       = (count_q < CNT_W'(DEPTH)) && rst && !flush;
    assign valid_instruction = not_empty && !head_cfg;
    assign instruction_in    = valid_instruction ? head_entry : '0;
    assign sew_temp          = sew_q;
    assign pending_count     = count_q;

    assign push = issue_valid && issue_ready;
    // Config ops leave the head unconditionally; ready_vector is only
    // honoured for entries actually presented.
    assign pop  = (valid_instruction && ready_vector) || head_cfg;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        sew_d   = sew_q;

        if (flush) begin
            // Flush wins over same-cycle push/pop; a config op sitting at
            // the head is discarded without touching sew.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (head_cfg) begin
                sew_d = cfg_sew(head_entry.instr[31:30],
                                head_entry.instr[25:23],
                                head_entry.rs2[5:3]);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            sew_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            sew_q   <= sew_d;
        end
    end

    // push is already gated by rst and flush through issue_ready.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_vec_issue_queue.sv
module tb_vec_issue_queue;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [31:0] issue_rs1;
    logic [31:0] issue_rs2;
    logic        issue_ready;
    logic        flush;
    logic [95:0] instruction_in;
    logic        valid_instruction;
    logic        ready_vector;
    logic [2:0]  sew_temp;
    logic [2:0]  pending_count;

    int n_checks;
    int n_fail;

    localparam logic [31:0] ARITH_BASE = 32'h0208_0057;
    localparam logic [31:0] VSETVLI_E16 = 32'h0100_7057; // [25:23]=010
    localparam logic [31:0] VSETVLI_E8x = 32'h0080_7057; // [25:23]=001
    localparam logic [31:0] VSETIVLI_RS = 32'hC280_7057; // [31:30]=11, [25:23]=101
    localparam logic [31:0] VSETVL_OP   = 32'h8300_7057; // [31:30]=10, [25:23]=110
    localparam logic [31:0] VADD        = 32'h0200_0057;

    vec_issue_queue #(
        .INSTRUCTION_BITS (32),
        .SCALAR_DATA_WIDTH(32),
        .DATA_FROM_SCALAR (96),
        .DEPTH            (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid      (issue_valid),
        .issue_instr      (issue_instr),
        .issue_rs1        (issue_rs1),
        .issue_rs2        (issue_rs2),
        .issue_ready      (issue_ready),
        .flush            (flush),
        .instruction_in   (instruction_in),
        .valid_instruction(valid_instruction),
        .ready_vector     (ready_vector),
        .sew_temp         (sew_temp),
        .pending_count    (pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i,
                         input logic [31:0] r1, input logic [31:0] r2);
        issue_valid = v;
        issue_instr = i;
        issue_rs1   = r1;
        issue_rs2   = r2;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; ready_vector = 1'b0;
        drive(1'b0, '0, '0, '0);
        step(); step();
        n_checks++; if (pending_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", pending_count); end
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", issue_ready); end
        n_checks++; if (valid_instruction !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_instruction); end
        n_checks++; if (instruction_in !== 96'd0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", instruction_in); end
        n_checks++; if (sew_temp !== 3'b000) begin n_fail++; $display("FAIL reset_sew got=%b exp=000", sew_temp); end
        rst = 1'b1;
        #1;
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", issue_ready); end
    endtask

    task automatic test_fill_drain();
        logic [95:0] exp;
        ready_vector = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ARITH_BASE + 32'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i));
            #1;
            if (i == 0) begin
                n_checks++; if (valid_instruction !== 1'b0) begin n_fail++; $display("FAIL no_bypass got=%b exp=0", valid_instruction); end
            end
            n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, issue_ready); end
            step();
            n_checks++; if (pending_count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, pending_count, i + 1); end
        end
        drive(1'b0, '0, '0, '0);
        #1;
        exp = {ARITH_BASE, 32'h2000, 32'h1000};
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", issue_ready); end
        n_checks++; if (instruction_in !== exp) begin n_fail++; $display("FAIL full_head got=%h exp=%h", instruction_in, exp); end
        for (int i = 0; i < 4; i++) begin
            ready_vector = 1'b1;
            // Offer an entry while full: it must be refused.
            if (i == 0) drive(1'b1, 32'hDEAD_0057, 32'hDEAD, 32'hBEEF);
            #1;
            n_checks++; if (instruction_in[95:64] !== ARITH_BASE + 32'(i)) begin n_fail++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, instruction_in[95:64], ARITH_BASE + 32'(i)); end
            step();
            drive(1'b0, '0, '0, '0);
            #1;
            n_checks++; if (pending_count !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, pending_count, 3 - i); end
            if (i == 0) begin
                n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_full_pop got=%b exp=1", issue_ready); end
            end
        end
        ready_vector = 1'b0;
        #1;
        n_checks++; if (valid_instruction !== 1'b0) begin n_fail++; $display("FAIL empty_valid got=%b exp=0", valid_instruction); end
        n_checks++; if (instruction_in !== 96'd0) begin n_fail++; $display("FAIL empty_instr got=%h exp=0", instruction_in); end
    endtask

    task automatic test_vsetvli();
        ready_vector = 1'b0;
        drive(1'b1, VSETVLI_E16, 32'h0, 32'h0);
        step();
        drive(1'b1, VADD, 32'hA, 32'hB);
        #1;
        n_checks++; if (valid_instruction !== 1'b0) begin n_fail++; $display("FAIL cfg_hidden got=%b exp=0", valid_instruction); end
        n_checks++; if (instruction_in !== 96'd0) begin n_fail++; $display("FAIL cfg_instr_zero got=%h exp=0", instruction_in); end
        n_checks++; if (sew_temp !== 3'b000) begin n_fail++; $display("FAIL cfg_sew_before got=%b exp=000", sew_temp); end
        step();
        drive(1'b0, '0, '0, '0);
        #1;
        n_checks++; if (pending_count !== 3'd1) begin n_fail++; $display("FAIL cfg_count got=%0d exp=1", pending_count); end
        n_checks++; if (sew_temp !== 3'b010) begin n_fail++; $display("FAIL vsetvli_sew got=%b exp=010", sew_temp); end
        n_checks++; if (instruction_in !== {VADD, 32'hB, 32'hA}) begin n_fail++; $display("FAIL vadd_after_cfg got=%h exp=%h", instruction_in, {VADD, 32'hB, 32'hA}); end
        ready_vector = 1'b1;
        step();
        ready_vector = 1'b0;
        #1;
        n_checks++; if (pending_count !== 3'd0) begin n_fail++; $display("FAIL vadd_pop got=%0d exp=0", pending_count); end
    endtask

    task automatic test_vsetvl();
        ready_vector = 1'b0;
        drive(1'b1, VSETIVLI_RS, 32'h0, 32'h18);
        step();
        drive(1'b1, VSETVL_OP, 32'h0, 32'h18);
        step();
        drive(1'b0, '0, '0, '0);
        #1;
        n_checks++; if (sew_temp !== 3'b101) begin n_fail++; $display("FAIL reserved_sew got=%b exp=101", sew_temp); end
        n_checks++; if (valid_instruction !== 1'b0) begin n_fail++; $display("FAIL vsetvl_hidden got=%b exp=0", valid_instruction); end
        step();
        n_checks++; if (sew_temp !== 3'b011) begin n_fail++; $display("FAIL vsetvl_sew got=%b exp=011", sew_temp); end
        n_checks++; if (pending_count !== 3'd0) begin n_fail++; $display("FAIL vsetvl_count got=%0d exp=0", pending_count); end
    endtask

    task automatic test_back_to_back();
        logic [95:0] e [5];
        for (int i = 0; i < 5; i++)
            e[i] = {32'h0300_0057 + 32'(i), 32'h3200 + 32'(i), 32'h3100 + 32'(i)};
        ready_vector = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, e[i][95:64], e[i][31:0], e[i][63:32]);
            step();
        end
        drive(1'b0, '0, '0, '0);
        ready_vector = 1'b1;
        #1;
        n_checks++; if (instruction_in !== e[0]) begin n_fail++; $display("FAIL b2b_head0 got=%h exp=%h", instruction_in, e[0]); end
        step();
        for (int i = 3; i < 5; i++) begin
            drive(1'b1, e[i][95:64], e[i][31:0], e[i][63:32]);
            #1;
            n_checks++; if (instruction_in !== e[i - 2]) begin n_fail++; $display("FAIL b2b_head[%0d] got=%h exp=%h", i - 2, instruction_in, e[i - 2]); end
            step();
            n_checks++; if (pending_count !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, pending_count); end
        end
        drive(1'b0, '0, '0, '0);
        #1;
        n_checks++; if (instruction_in !== e[3]) begin n_fail++; $display("FAIL b2b_drain3 got=%h exp=%h", instruction_in, e[3]); end
        step();
        n_checks++; if (instruction_in !== e[4]) begin n_fail++; $display("FAIL wrap_data got=%h exp=%h", instruction_in, e[4]); end
        step();
        ready_vector = 1'b0;
        #1;
        n_checks++; if (pending_count !== 3'd0) begin n_fail++; $display("FAIL b2b_empty got=%0d exp=0", pending_count); end
    endtask

    task automatic test_flush();
        ready_vector = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ARITH_BASE + 32'(i), 32'h50 + 32'(i), 32'h60 + 32'(i));
            step();
        end
        flush = 1'b1;
        drive(1'b1, 32'h0777_0057, 32'h7, 32'h7);
        #1;
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", issue_ready); end
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        #1;
        n_checks++; if (pending_count !== 3'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", pending_count); end
        n_checks++; if (valid_instruction !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", valid_instruction); end
        n_checks++; if (sew_temp !== 3'b011) begin n_fail++; $display("FAIL flush_sew got=%b exp=011", sew_temp); end
        // Config op at head while flushing must not update sew.
        drive(1'b1, VSETVLI_E8x, 32'h0, 32'h0);
        step();
        drive(1'b0, '0, '0, '0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        n_checks++; if (sew_temp !== 3'b011) begin n_fail++; $display("FAIL flush_cfg_sew got=%b exp=011", sew_temp); end
        n_checks++; if (pending_count !== 3'd0) begin n_fail++; $display("FAIL flush_cfg_count got=%0d exp=0", pending_count); end
        drive(1'b1, 32'h0400_0057, 32'h1, 32'h2);
        step();
        drive(1'b0, '0, '0, '0);
        #1;
        n_checks++; if (instruction_in !== {32'h0400_0057, 32'h2, 32'h1}) begin n_fail++; $display("FAIL post_flush_data got=%h exp=%h", instruction_in, {32'h0400_0057, 32'h2, 32'h1}); end
        ready_vector = 1'b1;
        step();
        ready_vector = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready_vector = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ARITH_BASE + 32'(i), 32'h90, 32'h91);
            step();
        end
        drive(1'b0, '0, '0, '0);
        #1;
        n_checks++; if (pending_count !== 3'd2) begin n_fail++; $display("FAIL pre_reset_count got=%0d exp=2", pending_count); end
        rst = 1'b0;
        #1;
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL in_reset_ready got=%b exp=0", issue_ready); end
        step();
        rst = 1'b1;
        #1;
        n_checks++; if (pending_count !== 3'd0) begin n_fail++; $display("FAIL mid_reset_count got=%0d exp=0", pending_count); end
        n_checks++; if (sew_temp !== 3'b000) begin n_fail++; $display("FAIL mid_reset_sew got=%b exp=000", sew_temp); end
        n_checks++; if (instruction_in !== 96'd0) begin n_fail++; $display("FAIL mid_reset_instr got=%h exp=0", instruction_in); end
        n_checks++; if (valid_instruction !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b exp=0", valid_instruction); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill_drain();
        test_vsetvli();
        test_vsetvl();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
